// File: rtl/mips_mc_control.sv
// Multi-cycle main control FSM for the MIPS core: sequences fetch, decode,
// execute, memory access and writeback over a req/ready memory with timeout.
module mips_mc_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_load,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [1:0]         ALU_op,
    output logic               ALU_src,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic               bus_error,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB     = 4'd6,
        S_BR_CMP = 4'd7,
        S_BR_RES = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    state_t             end_s;
    logic [5:0]         opcode_r;
    logic [WAIT_W-1:0]  wait_r;
    logic [COUNT_W-1:0] count_r;

    logic       retire_s;
    logic       mem_state_s;
    logic       timeout_s;
    logic       is_r_s;
    logic       mem_req_s;
    logic       mem_we_s;
    logic       ir_load_s;
    logic       pc_write_s;
    logic [1:0] pc_src_s;
    logic [1:0] alu_op_s;
    logic       alu_src_s;
    logic       reg_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       illegal_op_s;
    logic       bus_error_s;
    logic       halted_s;

    assign is_r_s      = (opcode_r == OP_R);
    assign end_s       = run ? S_FETCH : S_IDLE;
    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    // A ready response in the last allowed cycle takes priority over the timeout.
    assign timeout_s   = mem_state_s && !mem_ready && (wait_r == WAIT_LAST);

    // Next-state and control decode.
    always_comb begin
        state_s      = state_r;
        retire_s     = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        ir_load_s    = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 2'b00;
        alu_op_s     = 2'b00;
        alu_src_s    = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        illegal_op_s = 1'b0;
        bus_error_s  = 1'b0;
        halted_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) state_s = S_FETCH;
                else     state_s = S_IDLE;
            end
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_load_s  = 1'b1;
                    pc_write_s = 1'b1;
                    state_s    = S_DECODE;
                end else if (timeout_s) begin
                    bus_error_s = 1'b1;
                    state_s     = S_HALT;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_ADDI, OP_LW, OP_SW: state_s = S_EXEC;
                    OP_BEQ:                      state_s = S_BR_CMP;
                    OP_J:                        state_s = S_JUMP;
                    default: begin
                        illegal_op_s = 1'b1;
                        state_s      = end_s;
                    end
                endcase
            end
            S_EXEC: begin
                alu_op_s  = is_r_s ? 2'b10 : 2'b00;
                alu_src_s = !is_r_s;
                case (opcode_r)
                    OP_LW:   state_s = S_MEM_RD;
                    OP_SW:   state_s = S_MEM_WR;
                    default: state_s = S_WB;
                endcase
            end
            S_MEM_RD: begin
                alu_op_s  = is_r_s ? 2'b10 : 2'b00;
                alu_src_s = !is_r_s;
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    state_s = S_WB;
                end else if (timeout_s) begin
                    bus_error_s = 1'b1;
                    state_s     = S_HALT;
                end else begin
                    state_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                alu_op_s  = is_r_s ? 2'b10 : 2'b00;
                alu_src_s = !is_r_s;
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_s  = end_s;
                end else if (timeout_s) begin
                    bus_error_s = 1'b1;
                    state_s     = S_HALT;
                end else begin
                    state_s = S_MEM_WR;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = is_r_s;
                mem_to_reg_s = (opcode_r == OP_LW);
                retire_s     = 1'b1;
                state_s      = end_s;
            end
            // zero only becomes valid once the execute unit has registered the compare.
            S_BR_CMP: begin
                alu_op_s = 2'b01;
                state_s  = S_BR_RES;
            end
            S_BR_RES: begin
                alu_op_s = 2'b01;
                if (zero) begin
                    pc_write_s = 1'b1;
                    pc_src_s   = 2'b01;
                end else begin
                    pc_write_s = 1'b0;
                end
                retire_s = 1'b1;
                state_s  = end_s;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_src_s   = 2'b10;
                retire_s   = 1'b1;
                state_s    = end_s;
            end
            S_HALT: begin
                halted_s = 1'b1;
                state_s  = S_HALT;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Reset forces every output low so an aborted instruction performs no writes.
    assign mem_req     = !reset && mem_req_s;
    assign mem_we      = !reset && mem_we_s;
    assign ir_load     = !reset && ir_load_s;
    assign pc_write    = !reset && pc_write_s;
    assign pc_src      = reset ? 2'b00 : pc_src_s;
    assign ALU_op      = reset ? 2'b00 : alu_op_s;
    assign ALU_src     = !reset && alu_src_s;
    assign reg_write   = !reset && reg_write_s;
    assign reg_dst     = !reset && reg_dst_s;
    assign mem_to_reg  = !reset && mem_to_reg_s;
    assign illegal_op  = !reset && illegal_op_s;
    assign bus_error   = !reset && bus_error_s;
    assign halted      = !reset && halted_s;
    assign instr_count = reset ? {COUNT_W{1'b0}} : count_r;

    // State, latched opcode, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            opcode_r <= 6'b000000;
            wait_r   <= {WAIT_W{1'b0}};
            count_r  <= {COUNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == S_DECODE) opcode_r <= opcode;
            else                     opcode_r <= opcode_r;
            if (state_s != state_r)             wait_r <= {WAIT_W{1'b0}};
            else if (mem_state_s && !mem_ready) wait_r <= wait_r + WAIT_W'(1);
            else                                wait_r <= wait_r;
            if (retire_s) count_r <= count_r + COUNT_W'(1);
            else          count_r <= count_r;
        end
    end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle main control FSM for the MIPS core.
- Sequences instruction fetch, decode, the execute unit (drives its ALU_op/ALU_src), data memory access and register writeback, one instruction at a time.
- Talks to a shared single-port memory through a req/ready handshake with timeout.
- Sits beside the datapath; all datapath enables come from here.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus error (>=2)
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all flops posedge
reset  in  1  synchronous, active-high
run  in  1  level; allows leaving IDLE / starting next fetch
opcode  in  6  instr[31:26] from instruction register, valid from DECODE onward
zero  in  1  ALU zero flag from execute unit
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read (valid while mem_req)
ir_load  out  1  load instruction register from memory read data
pc_write  out  1  update PC this cycle
pc_src  out  2  00=PC+4, 01=branch target (new_address), 10=jump target
ALU_op  out  2  to execute unit: 00 add, 01 sub, 10 funct-decoded
ALU_src  out  1  0=read_data_2, 1=extended_offset
reg_write  out  1  register file write enable
reg_dst  out  1  1=rd, 0=rt
mem_to_reg  out  1  1=writeback memory data, 0=ALU_result
illegal_op  out  1  one-cycle pulse on unsupported opcode
bus_error  out  1  one-cycle pulse on memory timeout
halted  out  1  high while in HALT
instr_count  out  COUNT_W  retired instructions, wraps at 2^COUNT_W

Behaviour:
- Flops: state, opcode_q (6), wait_cnt, instr_count. All other outputs are combinational decodes of state/opcode_q/mem_ready/zero.
- Reset: state=IDLE, opcode_q=0, wait_cnt=0, instr_count=0. Every output is 0 during and immediately after reset. Reset mid-instruction aborts it with no further writes.
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- IDLE: no controls asserted. run=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0.
  - When mem_ready: ir_load=1, pc_write=1, pc_src=00, -> DECODE.
- DECODE: opcode_q<=opcode.
  - R/addi/lw/sw -> EXEC.
  - beq -> BR_CMP.
  - j -> JUMP.
  - Other -> illegal_op=1, -> FETCH (or IDLE if run=0).
- EXEC: one cycle.
  - ALU_op=10 for R, else 00.
  - ALU_src=0 for R, else 1.
  - Next: lw -> MEM_RD, sw -> MEM_WR, R/addi -> WB.
- MEM_RD: ALU_op/ALU_src held as in EXEC; mem_req=1, mem_we=0. When mem_ready -> WB.
- MEM_WR: ALU_op/ALU_src held as in EXEC; mem_req=1, mem_we=1. When mem_ready -> retire, -> FETCH/IDLE.
- WB: reg_write=1 for one cycle.
  - reg_dst=1 for R only.
  - mem_to_reg=1 for lw only.
  - Retire, -> FETCH/IDLE.
- BR_CMP: ALU_op=01, ALU_src=0. -> BR_RES. The execute unit registers its controls, so zero is not valid until the next cycle.
- BR_RES: ALU_op=01, ALU_src=0 held.
  - If zero=1: pc_write=1, pc_src=01.
  - Retire, -> FETCH/IDLE.
- JUMP: pc_write=1, pc_src=10. Retire, -> FETCH/IDLE.
- Retire: instr_count+1, modulo wrap. Illegal ops do not retire.
- FETCH/IDLE choice: at every instruction end, go to FETCH if run=1, else IDLE. run is not sampled elsewhere; an in-flight instruction always completes.
- Timeout: wait_cnt clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0 in those states.
  - If mem_ready=0 with wait_cnt==MEM_TIMEOUT-1: bus_error=1, -> HALT, no writes that cycle.
  - mem_ready=1 in that same cycle wins (no error).
- HALT: halted=1, all other controls 0, remains until reset.
- mem_ready outside FETCH/MEM_RD/MEM_WR: ignored.
- Latencies with zero-wait memory:
  - R/addi: 4 cycles.
  - lw: 5.
  - sw: 4.
  - beq: 4.
  - j: 3.

Test Plan:
- Reset, run=1, mem_ready=1 always, opcode=000000 -> state sequence FETCH,DECODE,EXEC,WB; EXEC shows ALU_op=10 ALU_src=0; WB shows reg_write=1 reg_dst=1 mem_to_reg=0; instr_count=1 after 4 cycles.
- lw (100011) with mem_ready delayed 3 cycles in MEM_RD -> mem_req=1 mem_we=0 held 4 cycles; then WB with mem_to_reg=1 reg_dst=0; total 8 cycles; sw (101011) -> mem_we=1 and no reg_write.
- beq with zero=1 in BR_RES -> pc_write=1 pc_src=01. Repeat with zero=0 -> pc_write=0. Both retire (count +1) and show ALU_op=01 in BR_CMP/BR_RES.
- opcode=111111 -> illegal_op pulse exactly 1 cycle in DECODE, next state FETCH, instr_count unchanged. j (000010) -> pc_src=10 pc_write=1 in cycle 3.
- MEM_TIMEOUT=16, mem_ready=0 in FETCH -> bus_error pulse at 16th FETCH cycle, then halted=1 with all controls 0 until reset. Second run: mem_ready=1 exactly on the 16th cycle -> no error.
- run dropped mid-lw -> lw completes (reg_write pulse) then IDLE. Reset asserted during MEM_WR -> next cycle all outputs 0, state IDLE, instr_count=0.
